sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Serial pattern transmitter: on command, emits a fixed or loaded bit pattern MSB-first, one bit per accepted handshake.
- Repeats the pattern N frames, with a programmable idle gap between frames.
- Source side of the serial stream consumed by the team's sequence detectors; default pattern is 101101.
- Used for self-test stimulus and link-pattern injection.

Parameters:
PATTERN_W, 6, pattern length in bits (>=2)
PATTERN, 6'b101101, built-in pattern, MSB sent first
CNT_W, 4, width of frame repeat count
GAP_CYCLES, 2, idle cycles between frames (0 = back-to-back)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin transmission (sampled in IDLE only)
abort  input  1  synchronous cancel of current transmission
repeat_cnt  input  CNT_W  frames to send; 0 treated as 1
pattern_sel  input  1  0 = PATTERN parameter, 1 = pattern_in
pattern_in  input  PATTERN_W  runtime pattern, captured at start
out_ready  input  1  sink accepts current bit
out_bit  output  1  serial data bit
out_valid  output  1  out_bit is valid
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after last bit of last frame

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; out_bit=0, out_valid=0, busy=0, done=0; shift register and counters cleared. Mid-operation reset aborts immediately with no done pulse.
- States: IDLE, SEND, GAP. All outputs are registered.
- IDLE: when start=1 and abort=0, capture the selected pattern into the shift register and capture frame count (repeat_cnt, with 0 mapped to 1). Next cycle: SEND, busy=1, out_valid=1, out_bit=pattern MSB. Start-to-first-valid latency is 1 cycle.
- start is ignored while busy=1.
- Handshake: a bit transfers on a cycle with out_valid=1 and out_ready=1. While out_ready=0, out_bit and out_valid hold stable.
- SEND, non-last bit transferred: the next bit is presented the following cycle with no bubble.
- SEND, last bit transferred, frames remain:
  - decrement frame count and reload the shift register from the captured pattern (not from pattern_in live);
  - GAP_CYCLES>0: enter GAP, out_valid=0, out_bit=0 for exactly GAP_CYCLES cycles, independent of out_ready, then SEND with MSB;
  - GAP_CYCLES=0: present the next frame's MSB the following cycle.
- SEND, last bit of last frame transferred: next cycle state IDLE, out_valid=0, busy=0, done=1 for exactly one cycle. A start in that done cycle is accepted.
- abort=1 in SEND or GAP: next cycle IDLE, out_valid=0, out_bit=0, busy=0, no done pulse. abort in IDLE: no effect, and it blocks a simultaneous start (abort wins).
- Bit counter width is clog2(PATTERN_W+1). Frame counter is CNT_W bits and never wraps below 1 while busy.

Optional Feature:
PARITY_EN
- Defined: each frame carries one extra bit after the pattern LSB, even parity (XOR of all captured pattern bits). It uses the same handshake and is sent before any gap, so frame length is PATTERN_W+1.
- Undefined: frame is exactly PATTERN_W bits and no parity logic is present.

Test Plan:
- start=1, repeat_cnt=1, pattern_sel=0, out_ready=1 → out_valid high cycles 1-6 after start with out_bit 1,0,1,1,0,1; done=1 at cycle 7, busy low at cycle 7.
- repeat_cnt=2, GAP_CYCLES=2, out_ready=1 → 6 bits, exactly 2 cycles out_valid=0, 6 bits, then one done pulse (15 cycles start to done).
- out_ready alternating 1/0 with pattern_sel=1, pattern_in=6'b110010 → out_bit stable during stalls; accepted sequence 1,1,0,0,1,0; done after the 6th accept.
- abort asserted after 3rd accepted bit, plus start pulsed mid-frame → out_valid=0 and busy=0 next cycle; no done pulse; mid-frame start ignored.
- reset driven low mid-GAP → outputs 0 immediately. After release, start with repeat_cnt=0 → exactly one frame, then done.
- PARITY_EN defined, pattern_sel=1, pattern_in=6'b111000 → 7 bits 1,1,1,0,0,0,1; with PATTERN=101101 the 7th bit is 0.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: N frames of a fixed/loaded pattern, MSB first, with an idle gap between frames.
// First bit valid 1 cycle after start; bits hold while out_ready=0. Optional PARITY_EN appends an even-parity bit.
module sequence_generator #(
  parameter int                   PATTERN_W  = 6,
  parameter logic [PATTERN_W-1:0] PATTERN    = 6'b101101,
  parameter int                   CNT_W      = 4,
  parameter int                   GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     repeat_cnt,
  input  logic                 pattern_sel,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 out_ready,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = $clog2(PATTERN_W + 1);
`ifdef PARITY_EN
  localparam int FRAME_LEN = PATTERN_W + 1;
`else
  localparam int FRAME_LEN = PATTERN_W;
`endif
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     frames_q, frames_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 out_bit_q, out_bit_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic [PATTERN_W-1:0] sel_pat;
  logic                 xfer, last_bit, last_frame, next_bit;

  assign sel_pat    = pattern_sel ? pattern_in : PATTERN;
  assign xfer       = out_valid_q && out_ready;
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign last_frame = (frames_q == CNT_W'(1));
`ifdef PARITY_EN
  assign next_bit   = (bit_cnt_q == BW'(PATTERN_W - 1)) ? parity_q : shift_q[PATTERN_W-1];
`else
  assign next_bit   = shift_q[PATTERN_W-1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !abort) state_d = S_SEND;
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer && last_bit) begin
          if (last_frame)          state_d = S_IDLE;
          else if (GAP_CYCLES > 0) state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (abort)                       state_d = S_IDLE;
        else if (gap_cnt_q == GAP_LAST)  state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pat_d       = pat_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frames_d    = frames_q;
    gap_cnt_d   = gap_cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d       = sel_pat;
          frames_d    = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
          bit_cnt_d   = '0;
          out_bit_d   = sel_pat[PATTERN_W-1];
          shift_d     = {sel_pat[PATTERN_W-2:0], 1'b0};
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifdef PARITY_EN
          parity_d    = ^sel_pat;
`endif
        end
      end
      S_SEND: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_bit_d   = 1'b0;
          busy_d      = 1'b0;
        end else if (xfer && !last_bit) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          out_bit_d = next_bit;
          shift_d   = {shift_q[PATTERN_W-2:0], 1'b0};
        end else if (xfer && last_frame) begin
          out_valid_d = 1'b0;
          out_bit_d   = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if (xfer) begin
          // Later frames replay the captured pattern, never the live pattern_in.
          frames_d  = frames_q - CNT_W'(1);
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            gap_cnt_d   = '0;
          end else begin
            out_bit_d = pat_q[PATTERN_W-1];
            shift_d   = {pat_q[PATTERN_W-2:0], 1'b0};
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_bit_d   = 1'b0;
          busy_d      = 1'b0;
        end else if (gap_cnt_q == GAP_LAST) begin
          out_valid_d = 1'b1;
          out_bit_d   = pat_q[PATTERN_W-1];
          shift_d     = {pat_q[PATTERN_W-2:0], 1'b0};
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frames_q    <= '0;
      gap_cnt_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      pat_q       <= pat_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frames_q    <= frames_d;
      gap_cnt_q   <= gap_cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: vector table, hand-written corner sequences, randomized frames vs. a queue model.
module tb_sequence_generator;

  localparam logic [5:0] PATTERN = 6'b101101;
  localparam int         GAP     = 2;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = 6 + PAR;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, pattern_sel, out_ready;
  logic [3:0] repeat_cnt;
  logic [5:0] pattern_in;
  logic       out_bit, out_valid, busy, done;

  sequence_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .repeat_cnt (repeat_cnt),
    .pattern_sel(pattern_sel),
    .pattern_in (pattern_in),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef bit bitq_t[$];
  typedef struct {
    logic       st, ab;
    logic [3:0] rc;
    logic       sel;
    logic [5:0] pin;
    logic       rdy;
    logic       ev, eb, ebusy, edone;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bit stream of one frame: pattern MSB first, then even parity when enabled.
  function automatic bitq_t frame_of(input logic [5:0] p);
    bitq_t q;
    for (int i = 5; i >= 0; i--) q.push_back(p[i]);
    if (PAR != 0) q.push_back(^p);
    return q;
  endfunction

  function automatic void add_vec(input logic st, input logic ab, input logic [3:0] rc,
                                  input logic sel, input logic [5:0] pin, input logic rdy,
                                  input logic ev, input logic eb, input logic ebusy,
                                  input logic edone);
    vec_t v;
    v = '{st, ab, rc, sel, pin, rdy, ev, eb, ebusy, edone};
    vecs.push_back(v);
  endfunction

  initial begin
    bitq_t      f, q;
    logic [5:0] pat;
    logic [3:0] rc;
    logic       pv, pb, rdy;
    int         cyc, lows, nbits, acc, gaps, nfr;

    reset = 1'b0; start = 1'b0; abort = 1'b0; repeat_cnt = '0;
    pattern_sel = 1'b0; pattern_in = '0; out_ready = 1'b0;

    // Default pattern, ready always high, then a start in the done cycle.
    f = frame_of(PATTERN);
    add_vec(1, 0, 4'd1, 0, 6'd0, 1, 1, f[0], 1, 0);
    for (int i = 1; i < FLEN; i++) add_vec(0, 0, 4'd1, 0, 6'd0, 1, 1, f[i], 1, 0);
    add_vec(0, 0, 4'd1, 0, 6'd0, 1, 0, 0, 0, 1);
    add_vec(1, 0, 4'd1, 0, 6'd0, 1, 1, f[0], 1, 0);
    for (int i = 1; i < FLEN; i++) add_vec(0, 0, 4'd1, 0, 6'd0, 1, 1, f[i], 1, 0);
    add_vec(0, 0, 4'd1, 0, 6'd0, 1, 0, 0, 0, 1);
    add_vec(0, 0, 4'd1, 0, 6'd0, 1, 0, 0, 0, 0);
    // Loaded pattern with out_ready alternating: bits must hold during stalls.
    f = frame_of(6'b110010);
    add_vec(1, 0, 4'd1, 1, 6'b110010, 0, 1, f[0], 1, 0);
    for (int i = 1; i < FLEN; i++) begin
      add_vec(0, 0, 4'd1, 1, 6'b000000, 1, 1, f[i], 1, 0);
      add_vec(0, 0, 4'd1, 1, 6'b000000, 0, 1, f[i], 1, 0);
    end
    add_vec(0, 0, 4'd1, 1, 6'd0, 1, 0, 0, 0, 1);
    add_vec(0, 0, 4'd1, 1, 6'd0, 0, 0, 0, 0, 0);
    // Abort in IDLE wins over a simultaneous start.
    add_vec(1, 1, 4'd1, 0, 6'd0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 4'd1, 0, 6'd0, 1, 0, 0, 0, 0);

    #3;
    chk("reset_valid", out_valid, 0);
    chk("reset_bit",   out_bit,   0);
    chk("reset_busy",  busy,      0);
    chk("reset_done",  done,      0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      start = vecs[i].st; abort = vecs[i].ab; repeat_cnt = vecs[i].rc;
      pattern_sel = vecs[i].sel; pattern_in = vecs[i].pin; out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_bit", i),   out_bit,   vecs[i].eb);
      chk($sformatf("vec%0d_busy", i),  busy,      vecs[i].ebusy);
      chk($sformatf("vec%0d_done", i),  done,      vecs[i].edone);
    end
    start = 0; abort = 0; pattern_sel = 0; out_ready = 1;

    // Two frames with the idle gap.
    repeat_cnt = 4'd2;
    start = 1; tick(); start = 0;
    cyc = 1; lows = 0; nbits = 0;
    while (!done && cyc < 60) begin
      if (out_valid) nbits++;
      else if (busy) lows++;
      tick(); cyc++;
    end
    chk("gap_start_to_done", cyc, 2 * FLEN + GAP + 1);
    chk("gap_idle_cycles", lows, GAP);
    chk("gap_bits", nbits, 2 * FLEN);
    tick();

    // Abort after the third accepted bit, with a start pulsed mid-frame.
    f = frame_of(PATTERN);
    repeat_cnt = 4'd3;
    start = 1; tick(); start = 0;
    tick();
    start = 1; tick(); start = 0;
    chk("midstart_bit", out_bit, f[2]);
    chk("midstart_busy", busy, 1);
    tick();
    chk("pre_abort_bit", out_bit, f[3]);
    abort = 1; tick(); abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_bit", out_bit, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_stays_idle", busy, 0);
    end

    // Abort while in the gap.
    repeat_cnt = 4'd2;
    start = 1; tick(); start = 0;
    repeat (FLEN) tick();
    chk("gapabort_in_gap", {out_valid, busy}, 2'b01);
    abort = 1; tick(); abort = 0;
    chk("gapabort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gapabort_no_done", {done, out_valid}, 2'b00);
    end

    // Reset mid-gap, then repeat_cnt=0 sends a single frame.
    start = 1; tick(); start = 0;
    repeat (FLEN) tick();
    chk("rstgap_in_gap", {out_valid, busy}, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("rstgap_outputs", {out_valid, out_bit, busy, done}, 4'b0000);
    #2 reset = 1'b1;
    repeat_cnt = 4'd0;
    start = 1; tick(); start = 0;
    cyc = 1; nbits = 0;
    while (!done && cyc < 40) begin
      if (out_valid) nbits++;
      tick(); cyc++;
    end
    chk("rc0_start_to_done", cyc, FLEN + 1);
    chk("rc0_bits", nbits, FLEN);
    tick();

    // Randomized transactions against the queue model.
    for (int t = 0; t < 20; t++) begin
      pattern_in  = 6'($urandom);
      pattern_sel = 1'($urandom);
      rc          = 4'($urandom_range(3));
      repeat_cnt  = rc;
      pat = pattern_sel ? pattern_in : PATTERN;
      nfr = (rc == 0) ? 1 : int'(rc);
      q.delete();
      for (int k = 0; k < nfr; k++) begin
        f = frame_of(pat);
        foreach (f[j]) q.push_back(f[j]);
      end
      out_ready = 1'($urandom);
      start = 1; tick(); start = 0;
      pattern_in = 6'($urandom);
      chk("rand_first_valid", {out_valid, busy}, 2'b11);
      acc = 0; gaps = 0; cyc = 0;
      while (q.size() != 0 && cyc < 400) begin
        pv = out_valid; pb = out_bit;
        rdy = ($urandom_range(3) != 0);
        out_ready = rdy;
        tick(); cyc++;
        if (pv && rdy) begin
          chk($sformatf("rand%0d_bit%0d", t, acc), pb, q.pop_front());
          acc++;
        end else if (pv) begin
          chk($sformatf("rand%0d_stall", t), {out_valid, out_bit}, {1'b1, pb});
        end
        if (!out_valid && busy) gaps++;
        if (out_valid && !pv) begin
          chk($sformatf("rand%0d_gap", t), gaps, GAP);
          gaps = 0;
        end
        chk($sformatf("rand%0d_done", t), done, (q.size() == 0));
      end
      chk($sformatf("rand%0d_left", t), q.size(), 0);
      chk($sformatf("rand%0d_busy_end", t), busy, 0);
      tick();
      chk($sformatf("rand%0d_done_clear", t), done, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
